block_mem_responder: RTL and testbench
======================================

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

Interface
REQ-001 SHALL provide parameter LATENCY, default 4: cycles from request acceptance to mem_ready; legal range 2..15.
REQ-002 SHALL provide parameter DEPTH_LOG2, default 6: log2 of the number of 128-bit storage blocks.
REQ-003 SHALL have one clock and an asynchronous active-low reset (clk, proc_reset_n); no other clock or reset exists.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port proc_reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mem_read  input  1  block read request, held by initiator until mem_ready.
REQ-007 SHALL have port mem_write  input  1  block write request, held by initiator until mem_ready.
REQ-008 SHALL have port mem_addr  input  28  block address; index = mem_addr[DEPTH_LOG2-1:0], upper bits ignored (aliasing).
REQ-009 SHALL have port mem_wdata  input  128  write block data.
REQ-010 SHALL have port mem_rdata  output  128  registered read block data, valid while mem_ready=1.
REQ-011 SHALL have port mem_ready  output  1  registered one-cycle completion pulse.
REQ-012 SHALL have port mem_busy  output  1  high in BUSY or RESP.

Function
REQ-013 SHALL implement storage of 2^DEPTH_LOG2 blocks × 128 bits, plus a 4-bit down-counter, latched op type (RD/WR) and FSM {IDLE, BUSY, RESP}.
REQ-014 IDLE: if mem_write=1 → BUSY, op=WR; else if mem_read=1 → BUSY, op=RD; counter loaded with LATENCY-2; nothing else sampled.
REQ-015 Both mem_read and mem_write high at acceptance SHALL be treated as WR.
REQ-016 Op type SHALL stay fixed from acceptance until return to IDLE; input changes between read/write after acceptance are ignored.
REQ-017 BUSY with mem_read=0 and mem_write=0: abort → IDLE next cycle; no mem_ready, no storage update.
REQ-018 BUSY with request held and counter≠0: counter decrements, stay BUSY.
REQ-019 BUSY with request held and counter=0 (final BUSY cycle): sample mem_addr index and mem_wdata at that edge; → RESP.
REQ-020 At that edge, op=WR SHALL write mem_wdata into the indexed block; op=RD SHALL load mem_rdata from the indexed block.
REQ-021 Address and data presented before the final BUSY cycle SHALL be don't-care; only final-BUSY-cycle values are used.
REQ-022 On op=WR, mem_rdata SHALL hold its previous value.
REQ-023 RESP: mem_ready=1 for exactly this one cycle; all inputs ignored; → IDLE unconditionally.
REQ-024 The initiator drops its request combinationally in the RESP cycle; the responder SHALL NOT require it held there.
REQ-025 Latency: request first high in IDLE at cycle T → mem_ready high at cycle T+LATENCY exactly.
REQ-026 A request in the IDLE cycle immediately after RESP SHALL be accepted, giving back-to-back throughput of one transaction per LATENCY+1 cycles.
REQ-027 A read issued after a completed write to the same index SHALL return the written data.
REQ-028 mem_busy SHALL be high in BUSY and RESP, low in IDLE.

Reset
REQ-029 proc_reset_n=0 SHALL asynchronously force FSM=IDLE, counter=0, op=RD, mem_ready=0, mem_rdata=0, mem_busy=0, and all storage blocks to zero.
REQ-030 Reset asserted mid-transaction SHALL abort it: no mem_ready pulse and no storage update for that transaction; the first request after reset release is accepted normally.

Verification
REQ-031 Read at reset: LATENCY=4, mem_read=1, addr=0x5 at cycle T → mem_ready=1 only at T+4, mem_rdata=0.
REQ-032 Write/read: write addr=0x3, wdata=0x0123...CDEF, held until ready; then read addr=0x3 → rdata=0x0123...CDEF; read addr=0x43 (DEPTH_LOG2=6 alias) → same data.
REQ-033 Late address: write with mem_addr=0 in the accept cycle, then 0x7 until ready → block 7 updated, block 0 still zero.
REQ-034 Abort: mem_read dropped in cycle T+2 → no mem_ready through T+10; FSM back in IDLE; next read completes in LATENCY cycles.
REQ-035 Simultaneous: mem_read=mem_write=1, addr=0x2, wdata=0xAA..AA → treated as write; subsequent read of 0x2 → 0xAA..AA.
REQ-036 Reset mid-op: proc_reset_n low at T+2 of a write → mem_ready, mem_busy and mem_rdata at 0 immediately; target block remains 0.

Source files
------------

// File: rtl/block_mem_responder.sv
// Block memory responder: 128-bit blocks, completes LATENCY cycles after a request is accepted.
// No backpressure; the initiator holds its request until mem_ready, and dropping it early aborts.
module block_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         mem_busy
);

    localparam int NBLK = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           op_wr_q, op_wr_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic [127:0]   rdata_q, rdata_d;
    logic [127:0]   mem_q [NBLK];
    logic           wr_en;
    logic [DEPTH_LOG2-1:0] idx;
    logic           unused_addr_bits;

    // Upper address bits alias onto the same blocks.
    assign idx              = mem_addr[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^mem_addr[27:DEPTH_LOG2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_write || mem_read) begin
                    state_d = ST_BUSY;
                    op_wr_d = mem_write;
                    cnt_d   = 4'(LATENCY - 2);
                    busy_d  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!mem_read && !mem_write) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Final busy cycle: address and data are only sampled here.
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    if (op_wr_q) begin
                        wr_en = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx];
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            for (int i = 0; i < NBLK; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= mem_wdata;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_busy  = busy_q;

endmodule

// File: tb/tb_block_mem_responder.sv
module tb_block_mem_responder;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         mem_busy;

    int ntests = 0;
    int nfail  = 0;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] D3 = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam logic [127:0] DA = {16{8'hAA}};
    localparam logic [127:0] JUNK = {4{32'hF00DF00D}};

    block_mem_responder #(.LATENCY(4), .DEPTH_LOG2(6)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_busy     (mem_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rd;
        logic         wr;
        logic [27:0]  a0;   // address in the accept cycle
        logic [27:0]  a1;   // address from the next cycle on
        logic [127:0] wd0;
        logic [127:0] wd1;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one transaction starting in the current IDLE cycle and checks
    // latency, pulse width, busy and rdata; returns at the next IDLE cycle.
    task automatic run_txn(input vec_t v, input string nm);
        int ready_at  = 0;
        int ready_cnt = 0;
        logic busy_ok = 1'b1;
        mem_read  = v.rd;
        mem_write = v.wr;
        mem_addr  = v.a0;
        mem_wdata = v.wd0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            mem_addr  = v.a1;
            mem_wdata = v.wd1;
            if (c <= 4 && mem_busy !== 1'b1) busy_ok = 1'b0;
            if (mem_ready === 1'b1) begin
                ready_cnt++;
                if (ready_at == 0) ready_at = c;
                chk({nm, " rdata"}, mem_rdata, v.exp_rdata);
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk({nm, " ready_cycle"}, 128'(ready_at), 128'd4);
        chk({nm, " ready_pulses"}, 128'(ready_cnt), 128'd1);
        chk({nm, " busy_during"}, 128'(busy_ok), 128'd1);
        chk({nm, " busy_after"}, 128'(mem_busy), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic saw_ready;

        //            rd    wr    a0         a1          wd0   wd1   exp_rdata
        vecs[0]  = '{1'b1, 1'b0, 28'h5,     28'h5,      JUNK, JUNK, '0};
        vecs[1]  = '{1'b0, 1'b1, 28'h3,     28'h3,      D1,   D1,   '0};
        vecs[2]  = '{1'b1, 1'b0, 28'h3,     28'h3,      JUNK, JUNK, D1};
        vecs[3]  = '{1'b1, 1'b0, 28'h43,    28'h43,     JUNK, JUNK, D1};
        vecs[4]  = '{1'b0, 1'b1, 28'h0,     28'h7,      JUNK, D2,   D1};
        vecs[5]  = '{1'b1, 1'b0, 28'h7,     28'h7,      JUNK, JUNK, D2};
        vecs[6]  = '{1'b1, 1'b0, 28'h0,     28'h0,      JUNK, JUNK, '0};
        vecs[7]  = '{1'b1, 1'b1, 28'h2,     28'h2,      DA,   DA,   '0};
        vecs[8]  = '{1'b1, 1'b0, 28'h2,     28'h2,      JUNK, JUNK, DA};
        vecs[9]  = '{1'b0, 1'b1, 28'h3F,    28'h3F,     JUNK, D3,   DA};
        vecs[10] = '{1'b1, 1'b0, 28'hFFFFFFF, 28'hFFFFFFF, JUNK, JUNK, D3};

        proc_reset_n = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        tick();
        tick();
        chk("reset ready", 128'(mem_ready), 128'd0);
        chk("reset busy", 128'(mem_busy), 128'd0);
        chk("reset rdata", mem_rdata, '0);
        proc_reset_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort: read dropped in cycle T+2.
        mem_read = 1'b1;
        mem_addr = 28'h5;
        tick();
        chk("abort busy_t1", 128'(mem_busy), 128'd1);
        tick();
        mem_read  = 1'b0;
        saw_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (mem_ready === 1'b1) saw_ready = 1'b1;
        end
        chk("abort no_ready", 128'(saw_ready), 128'd0);
        chk("abort idle_busy", 128'(mem_busy), 128'd0);
        chk("abort rdata_kept", mem_rdata, D3);
        run_txn('{1'b1, 1'b0, 28'h3, 28'h3, JUNK, JUNK, D1}, "post_abort");

        // Reset during a write at T+2.
        mem_write = 1'b1;
        mem_addr  = 28'h9;
        mem_wdata = D2;
        tick();
        tick();
        chk("rst_mid busy_before", 128'(mem_busy), 128'd1);
        proc_reset_n = 1'b0;
        #1;
        chk("rst_mid ready", 128'(mem_ready), 128'd0);
        chk("rst_mid busy", 128'(mem_busy), 128'd0);
        chk("rst_mid rdata", mem_rdata, '0);
        mem_write = 1'b0;
        tick();
        tick();
        proc_reset_n = 1'b1;
        tick();
        run_txn('{1'b1, 1'b0, 28'h9, 28'h9, JUNK, JUNK, '0}, "rst_block9");
        run_txn('{1'b1, 1'b0, 28'h3, 28'h3, JUNK, JUNK, '0}, "rst_block3");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
